// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST controller: FSM states,
// LFSR taps/width, MISR polynomial/width, and the LFSR step function.
package c17_bist_pkg;

  localparam int LFSR_W = 5;
  localparam int MISR_W = 8;

  // x^5 + x^3 + 1 as a Fibonacci shift-left: feedback is q[4] ^ q[2]
  localparam int LFSR_TAP_HI = 4;
  localparam int LFSR_TAP_LO = 2;

  localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// 8-bit multiple-input signature register compacting the two c17 responses.
// clr_i zeroes the signature, en_i folds resp_i in; clr_i wins.
module c17_bist_misr
  import c17_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [1:0]        resp_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0] misr_q;
  logic [MISR_W-1:0] misr_d;

  always_comb begin
    misr_d = misr_q;
    if (clr_i) begin
      misr_d = '0;
    end else if (en_i) begin
      misr_d = {misr_q[MISR_W-2:0], 1'b0}
             ^ (misr_q[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
             ^ {{(MISR_W-2){1'b0}}, resp_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign sig_o = misr_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for c17: LFSR pattern source, run counter and IDLE/RUN/DONE
// FSM; responses are compacted by c17_bist_misr and compared to GOLDEN_SIG.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int                NUM_PATTERNS = 31,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 5'b00001,
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        resp,
  output logic [LFSR_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam logic [4:0] LAST_CNT = 5'(NUM_PATTERNS - 1);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              misr_clr;
  logic              misr_en;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          lfsr_d   = LFSR_SEED;
          cnt_d    = 5'd0;
          misr_clr = 1'b1;
        end
      end
      ST_RUN: begin
        // The pattern on the CUT this cycle is captured at this edge
        misr_en = 1'b1;
        lfsr_d  = lfsr_next(lfsr_q);
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

  c17_bist_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .resp_i (resp),
    .sig_o  (signature)
  );

  assign pattern = lfsr_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign pass    = done && (signature == GOLDEN_SIG);

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench: four controller instances (real c17 / zero response /
// wrong golden / single pattern) checked every cycle against a position-based model.
module tb_c17_bist_ctrl;

  // ---- reference arithmetic ------------------------------------------------
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    n1 = p[4]; n2 = p[3]; n3 = p[2]; n6 = p[1]; n7 = p[0];
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic logic [4:0] lfsr_step(input logic [4:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

  function automatic logic [4:0] lfsr_at(input int k);
    logic [4:0] q;
    q = 5'b00001;
    for (int j = 0; j < k; j++) q = lfsr_step(q);
    return q;
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x^2+1, then add the response bits
  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [1:0] r);
    logic [8:0] w;
    w = {m, 1'b0};
    if (w[8]) w = w ^ 9'h11D;
    return w[7:0] ^ {6'b0, r};
  endfunction

  function automatic logic [7:0] ref_sig(input int n);
    logic [7:0] m;
    m = 8'h00;
    for (int k = 0; k < n; k++) m = misr_step(m, c17(lfsr_at(k)));
    return m;
  endfunction

  localparam logic [7:0] REF31 = ref_sig(31);

  // ---- DUTs ------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] pat    [4];
  logic       busy_w [4];
  logic       done_w [4];
  logic       pass_w [4];
  logic [7:0] sig    [4];
  logic [1:0] resp_w [4];

  always #5 clk = ~clk;

  assign resp_w[0] = c17(pat[0]);
  assign resp_w[1] = 2'b00;
  assign resp_w[2] = 2'b00;
  assign resp_w[3] = c17(pat[3]);

  c17_bist_ctrl #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001), .GOLDEN_SIG(REF31)) u_cut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp_w[0]), .pattern(pat[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .signature(sig[0]));

  c17_bist_ctrl #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001), .GOLDEN_SIG(8'h00)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp_w[1]), .pattern(pat[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .signature(sig[1]));

  c17_bist_ctrl #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001), .GOLDEN_SIG(8'h01)) u_zero1 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp_w[2]), .pattern(pat[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .signature(sig[2]));

  c17_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(5'b00001), .GOLDEN_SIG(8'h01)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp_w[3]), .pattern(pat[3]),
    .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .signature(sig[3]));

  // ---- model: mode 0=idle 1=run 2=done, pos = index of pattern being applied
  int         np_t   [4] = '{31, 31, 31, 1};
  bit         c17_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] gold_t [4] = '{REF31, 8'h00, 8'h01, 8'h01};
  int         m_mode [4] = '{0, 0, 0, 0};
  int         m_pos  [4] = '{0, 0, 0, 0};
  logic [7:0] m_sig  [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_mode[i] <= 0;
        m_pos[i]  <= 0;
        m_sig[i]  <= 8'h00;
      end else if (m_mode[i] != 1) begin
        if (start) begin
          m_mode[i] <= 1;
          m_pos[i]  <= 0;
          m_sig[i]  <= 8'h00;
        end
      end else begin
        m_sig[i] <= misr_step(m_sig[i], c17_t[i] ? c17(lfsr_at(m_pos[i])) : 2'b00);
        m_pos[i] <= m_pos[i] + 1;
        if (m_pos[i] + 1 == np_t[i]) m_mode[i] <= 2;
      end
    end
  end

  function automatic logic [4:0] exp_pat(input int mode, input int pos, input int np);
    if (mode == 1) return lfsr_at(pos);
    if (mode == 2) return lfsr_at(np);
    return lfsr_at(0);
  endfunction

  // ---- checking ----------------------------------------------------------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("busy_u%0d", i), 8'(busy_w[i]), 8'(m_mode[i] == 1));
        check($sformatf("done_u%0d", i), 8'(done_w[i]), 8'(m_mode[i] == 2));
        check($sformatf("pass_u%0d", i), 8'(pass_w[i]),
              8'((m_mode[i] == 2) && (m_sig[i] == gold_t[i])));
        check($sformatf("sig_u%0d", i), sig[i], m_sig[i]);
        check($sformatf("pat_u%0d", i), 8'(pat[i]), 8'(exp_pat(m_mode[i], m_pos[i], np_t[i])));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [4:0] first6 [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
  logic [31:0] seen;
  int seen_cnt;

  initial begin
    // Asynchronous reset asserted mid-cycle, before any clock edge
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy_u%0d", i), 8'(busy_w[i]), 8'h00);
      check($sformatf("rst_done_u%0d", i), 8'(done_w[i]), 8'h00);
      check($sformatf("rst_pass_u%0d", i), 8'(pass_w[i]), 8'h00);
      check($sformatf("rst_sig_u%0d", i), sig[i], 8'h00);
      check($sformatf("rst_pat_u%0d", i), 8'(pat[i]), 8'h01);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick();
    $display("idle: 10 cycles without start");

    // Full run; start pulse in RUN cycle 5 must be ignored by the 31-pattern units
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = '0;
    seen_cnt = 0;
    for (int k = 0; k < 31; k++) begin
      if (k < 6) check($sformatf("lfsr_seq_k%0d", k), 8'(pat[0]), 8'(first6[k]));
      if (!seen[pat[0]]) seen_cnt++;
      seen[pat[0]] = 1'b1;
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    check("lfsr_unique_cnt", 8'(seen_cnt), 8'd31);
    check("lfsr_zero_absent", 8'(seen[0]), 8'h00);
    check("cut_done", 8'(done_w[0]), 8'h01);
    check("cut_sig_ref", sig[0], REF31);
    check("cut_pass", 8'(pass_w[0]), 8'h01);
    check("zero_sig", sig[1], 8'h00);
    check("zero_pass", 8'(pass_w[1]), 8'h01);
    check("zero_gold01_pass", 8'(pass_w[2]), 8'h00);
    check("one_sig", sig[3], 8'h01);
    check("one_pass", 8'(pass_w[3]), 8'h01);
    check("one_pat", 8'(pat[3]), 8'h02);
    $display("run1: cut signature %h (reference %h)", sig[0], REF31);

    // Restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_pat", 8'(pat[0]), 8'h01);
    check("restart_sig", sig[0], 8'h00);
    check("restart_busy", 8'(busy_w[0]), 8'h01);
    repeat (10) tick();

    // Reset in RUN cycle 10; start held through reset must be ignored
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 8'(busy_w[0]), 8'h00);
    check("midrst_done", 8'(done_w[0]), 8'h00);
    check("midrst_sig", sig[0], 8'h00);
    check("midrst_pass", 8'(pass_w[0]), 8'h00);
    check("midrst_pat", 8'(pat[0]), 8'h01);
    start = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    tick();
    check("post_rst_idle_busy", 8'(busy_w[0]), 8'h00);
    $display("reset mid-run: controller back in idle");

    // Fresh run after the interrupted one
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (31) tick();
    check("rerun_done", 8'(done_w[0]), 8'h01);
    check("rerun_sig_ref", sig[0], REF31);
    check("rerun_pass", 8'(pass_w[0]), 8'h01);
    $display("run2: cut signature %h", sig[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/c17_bist_ctrl.md
# c17_bist_ctrl

Clocked built-in self-test controller for the c17 benchmark netlist. It drives the five c17 inputs from a 5-bit LFSR pattern generator, samples the two c17 outputs each cycle, and compacts them into an 8-bit MISR signature. At the end of the run it compares the signature against a golden value. It wraps the combinational c17 core so that STA and PrimeTime runs have real register-to-register paths through the benchmark: launch from the pattern register, capture into the MISR.

## Interface
- NUM_PATTERNS, default 31: patterns applied per run, 1..31.
- LFSR_SEED, default 5'b00001: LFSR value loaded at start; must be nonzero.
- GOLDEN_SIG, default 8'h00: expected final MISR value.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset. Release is synchronous to clk at the integration level.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- resp  in  2  CUT responses: resp[1]=N22, resp[0]=N23.
- pattern  out  5  CUT stimulus {N1,N2,N3,N6,N7}, MSB first; registered.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1: signature == GOLDEN_SIG.
- signature  out  8  current MISR contents.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: if start=1, go to RUN next cycle; load pattern=LFSR_SEED, misr=0, cnt=0.
- RUN: each cycle sample resp into the MISR, advance the LFSR, increment cnt.
  - After the cycle with cnt==NUM_PATTERNS-1, go to DONE.
  - start is ignored in RUN.
- DONE: hold pattern, signature and pass; done=1. If start=1, restart exactly as from IDLE.
- LFSR: Fibonacci, x^5+x^3+1, maximal period 31.
  - next = {q[3:0], q[4]^q[2]}.
  - From 00001 the sequence is 00001, 00010, 00100, 01001, 10010, 00101, ...
- MISR: 8-bit, polynomial 0x1D (x^8+x^4+x^3+x^2+1).
  - fb = m[7].
  - next = {m[6:0],1'b0} ^ (fb ? 8'h1D : 8'h00) ^ {6'b0, resp}.
- cnt: 5 bits, unsigned. No wrap within a run because NUM_PATTERNS ≤ 31.
- pass: combinational compare of the registered signature, gated by done.

## Timing
- Reset values: pattern=LFSR_SEED, busy=0, done=0, pass=0, signature=8'h00, state=IDLE, cnt=0.
- Cycle 0: start high in IDLE. Cycle 1: busy=1, pattern=seed.
- In RUN cycle k, pattern holds the k-th LFSR value. resp from the combinational CUT is captured at the end of that same cycle.
- Run length is exactly NUM_PATTERNS cycles with busy=1. done rises the cycle after the last capture.
- Total latency from start to done is NUM_PATTERNS+1 cycles.
- Signature is final when done rises and is held until the next start.
- start coincident with reset deassertion is ignored; reset has priority.
- Reset asserted mid-run immediately forces all reset values. No partial signature survives, and pass=0.
- NUM_PATTERNS=1: a single capture, then DONE.

## Structure
- Package c17_bist_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - LFSR tap constants and MISR_POLY=8'h1D;
  - LFSR_W=5, MISR_W=8.
- One sub-module, c17_bist_misr, contains the MISR register with load-zero and enable inputs.
- The LFSR, counter and FSM live in c17_bist_ctrl.
- The c17 netlist is instantiated by the test wrapper, not inside this block.

## Test plan
- Reset and idle: assert rst_n=0 mid-cycle; outputs take reset values asynchronously. Hold IDLE without start for 10 cycles; busy=0, done=0.
- LFSR sequence: pulse start; the first six RUN-cycle patterns are 00001, 00010, 00100, 01001, 10010, 00101. With NUM_PATTERNS=31, all 31 nonzero values occur exactly once.
- Zero response: force resp=2'b00 with GOLDEN_SIG=8'h00.
  - busy is high for exactly 31 cycles and done rises at cycle 32.
  - signature=8'h00 and pass=1.
  - With GOLDEN_SIG=8'h01, pass=0.
- Real CUT: connect c17 and run a full run. The signature equals the bench reference model (same LFSR, MISR and c17 equations). Set GOLDEN_SIG to it; pass=1.
- Restart and ignore: a start pulse in RUN cycle 5 does not change the run length. A start in DONE restarts with misr=0 and pattern=00001 on the next cycle.
- Reset mid-run: assert rst_n in RUN cycle 10; state=IDLE and signature=0. A new start yields the same final signature as an uninterrupted run.
